cal_seq: RTL
============

CAL_SEQ -- requirements
Module: cal_seq

Interface
REQ-001 The block SHALL have port `clk_sys`: input, 1 bit, system clock; all logic on its rising edge.
REQ-002 The block SHALL have port `rst_n`: input, 1 bit, asynchronous active-low reset.
REQ-003 The block SHALL have port `wr_en`: input, 1 bit, register write strobe, one `clk_sys` cycle per write.
REQ-004 The block SHALL have port `wr_addr`: input, 2 bits, register select. 0 = para[5:0], 1 = on_len[15:0], 2 = gap_len[15:0], 3 = rpt[7:0].
REQ-005 The block SHALL have port `wr_data`: input, 16 bits, write data; LSBs used for narrower registers.
REQ-006 The block SHALL have port `go`: input, 1 bit, single-cycle request to start a calibration sequence.
REQ-007 The block SHALL have port `abort`: input, 1 bit, single-cycle request to terminate a sequence.
REQ-008 The block SHALL have port `cal_para`: output, 6 bits, calibration parameter to the downstream CAL stage.
REQ-009 The block SHALL have port `cal_load`: output, 1 bit, one-cycle load strobe to CAL.
REQ-010 The block SHALL have port `cal_start`: output, 1 bit, CAL enable level, high during each ON window.
REQ-011 The block SHALL have port `busy`: output, 1 bit, high whenever the FSM is not in IDLE.
REQ-012 The block SHALL have port `done`: output, 1 bit, one-cycle pulse on normal sequence completion.
REQ-013 The block SHALL have port `err`: output, 1 bit, one-cycle pulse when `go` is rejected.

Function
REQ-014 Register writes SHALL take effect only in IDLE; writes while `busy`=1 SHALL be ignored.
REQ-015 On an accepted `go`, the block SHALL copy para, on_len, gap_len and rpt into working copies; later writes SHALL NOT affect the running sequence.
REQ-016 If `wr_en` and `go` occur in the same IDLE cycle, the sequence SHALL use the pre-write register values, and the write SHALL complete.
REQ-017 `go` in IDLE with on_len=0 or rpt=0 SHALL be rejected: `err`=1 for one cycle, FSM stays in IDLE.
REQ-018 The FSM SHALL have the states IDLE, LOAD, SETTLE, ON, GAP and FIN.
REQ-019 Transition IDLE->LOAD SHALL occur on a valid `go`.
REQ-020 Transition LOAD->SETTLE SHALL occur after 1 cycle.
REQ-021 Transition SETTLE->ON SHALL occur after exactly 4 cycles.
REQ-022 Transition ON->GAP SHALL occur after on_len cycles, if the remaining repeat count is >1 and gap_len>0.
REQ-023 Transition ON->ON (a new window) SHALL occur if the remaining repeat count is >1 and gap_len=0; `cal_start` SHALL stay high continuously.
REQ-024 Transition ON->FIN SHALL occur when the remaining repeat count is 1.
REQ-025 Transition GAP->ON SHALL occur after gap_len cycles.
REQ-026 Transition FIN->IDLE SHALL occur after 1 cycle.
REQ-027 The remaining repeat count SHALL decrement at the end of each ON window.
REQ-028 `cal_load` SHALL be 1 exactly in the LOAD state.
REQ-029 `cal_start` SHALL be 1 exactly in the ON state.
REQ-030 `done` SHALL be 1 exactly in the FIN state.
REQ-031 `cal_para` SHALL be registered: it takes the working para on the `go` acceptance cycle, so it is stable from LOAD onward, and holds its value through IDLE until the next accepted `go`.
REQ-032 Latency: with `go` sampled high at edge n, `cal_load` SHALL be high in cycle n+1 and `cal_start` SHALL rise at cycle n+6.
REQ-033 Cycle counters SHALL be 16 bits; on_len/gap_len=16'hFFFF SHALL give 65535 cycles with no wrap.
REQ-034 `abort` in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with `cal_load`/`cal_start` low and no `done` pulse.
REQ-035 `abort` and `go` in the same IDLE cycle: `abort` SHALL win; no sequence starts and no `err` is raised.
REQ-036 `go` while `busy`=1 SHALL be ignored, with no `err`.

Reset
REQ-037 While `rst_n`=0, the block SHALL hold: FSM=IDLE, para=0, on_len=0, gap_len=0, rpt=0, `cal_para`=0, `cal_load`=0, `cal_start`=0, `busy`=0, `done`=0, `err`=0.
REQ-038 Reset asserted mid-sequence SHALL force all outputs low immediately, without waiting for a clock edge.
REQ-039 After reset, a new `go` SHALL be accepted only after the registers are rewritten; otherwise on_len=0 gives `err`.

Verification
REQ-040 The bench SHALL cover a basic sequence: para=6'h2A, on_len=10, gap_len=5, rpt=3, then `go` -> `cal_load` for 1 cycle with `cal_para`=2A; three `cal_start` windows of 10 cycles separated by 5-cycle gaps; first rise at n+6; `done` 1 cycle after the last window; `busy` deasserted after FIN.
REQ-041 The bench SHALL cover zero gap: on_len=4, gap_len=0, rpt=2 -> `cal_start` high for 8 continuous cycles, then `done`.
REQ-042 The bench SHALL cover rejection: rpt=0 then `go` -> `err` for 1 cycle, `busy` stays 0, `cal_load` never asserts.
REQ-043 The bench SHALL cover abort: `abort` 3 cycles into ON -> `cal_start`=0 and `busy`=0 on the next edge, no `done`; a subsequent `go` runs normally.
REQ-044 The bench SHALL cover writes while busy: write para=6'h3F during ON -> `cal_para` unchanged; para register still holds its old value in IDLE.
REQ-045 The bench SHALL cover asynchronous reset: `rst_n` low mid-GAP, between clock edges -> all outputs 0 immediately; after release, `go` without rewrites -> `err`.

Source files
------------

// File: rtl/cal_seq.sv
// Calibration sequencer: programmable ON/GAP window train with a fixed settle
// period, driving the downstream CAL stage through load/start/para.
module cal_seq (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [1:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic        go,
   input  logic        abort,
   output logic [5:0]  cal_para,
   output logic        cal_load,
   output logic        cal_start,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      ON,
      GAP,
      FIN
   } state_t;

   localparam logic [15:0] SETTLE_LAST = 16'd3;

   state_t      state;
   state_t      state_nxt;

   logic [5:0]  para_reg;
   logic [15:0] on_len_reg;
   logic [15:0] gap_len_reg;
   logic [7:0]  rpt_reg;

   logic [15:0] w_on_len;
   logic [15:0] w_gap_len;
   logic [7:0]  rem;
   logic [15:0] cnt;

   logic [15:0] cnt_nxt;
   logic [7:0]  rem_nxt;
   logic        go_idle;
   logic        start_ok;
   logic        reject;
   logic        reg_wr;

   // abort in IDLE suppresses both acceptance and rejection of go
   assign go_idle  = (state == IDLE) && go && !abort;
   assign start_ok = go_idle && (on_len_reg != 16'd0) && (rpt_reg != 8'd0);
   assign reject   = go_idle && ((on_len_reg == 16'd0) || (rpt_reg == 8'd0));
   assign reg_wr   = wr_en && (state == IDLE);

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // cnt holds cycles remaining minus one in the current timed state
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rem_nxt   = rem;
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_nxt = LOAD;
               rem_nxt   = rpt_reg;
            end
         end
         LOAD: begin
            state_nxt = SETTLE;
            cnt_nxt   = SETTLE_LAST;
         end
         SETTLE: begin
            if (cnt == 16'd0) begin
               state_nxt = ON;
               cnt_nxt   = w_on_len - 16'd1;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         ON: begin
            if (cnt == 16'd0) begin
               rem_nxt = rem - 8'd1;
               if (rem == 8'd1) begin
                  state_nxt = FIN;
               end else if (w_gap_len != 16'd0) begin
                  state_nxt = GAP;
                  cnt_nxt   = w_gap_len - 16'd1;
               end else begin
                  cnt_nxt = w_on_len - 16'd1;
               end
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         GAP: begin
            if (cnt == 16'd0) begin
               state_nxt = ON;
               cnt_nxt   = w_on_len - 16'd1;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      if (abort && (state != IDLE)) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         para_reg    <= 6'd0;
         on_len_reg  <= 16'd0;
         gap_len_reg <= 16'd0;
         rpt_reg     <= 8'd0;
      end else if (reg_wr) begin
         case (wr_addr)
            2'd0:    para_reg    <= wr_data[5:0];
            2'd1:    on_len_reg  <= wr_data;
            2'd2:    gap_len_reg <= wr_data;
            default: rpt_reg     <= wr_data[7:0];
         endcase
      end
   end

   // working copies are captured from the pre-write register values on go
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         w_on_len  <= 16'd0;
         w_gap_len <= 16'd0;
         cal_para  <= 6'd0;
         cnt       <= 16'd0;
         rem       <= 8'd0;
         err       <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         rem <= rem_nxt;
         err <= reject;
         if (start_ok) begin
            w_on_len  <= on_len_reg;
            w_gap_len <= gap_len_reg;
            cal_para  <= para_reg;
         end
      end
   end

   assign cal_load  = (state == LOAD);
   assign cal_start = (state == ON);
   assign done      = (state == FIN);
   assign busy      = (state != IDLE);

endmodule
